sha1_core: RTL

Iterative SHA-1 compression core that closes the open core slot in the `sha1` wrapper. It takes one 512-bit block from the register interface, runs the 80 SHA-1 rounds over a configurable number of cycles, and chains the 160-bit hash state across blocks. Its control and status ports map one-to-one onto the `enable_hash`/`reset_hash`/`hold`/`idle`/`digest` signals of `simple_reg_interface`.

---
 rtl/sha1_core.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression core: one 512-bit block per start, RoundsPerCycle
// rounds per clock, with the 160-bit hash state chained across blocks.
module sha1_core #(
  parameter int RoundsPerCycle = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_hash_i,
  input  logic         reset_hash_i,
  input  logic [511:0] block_i,
  output logic         hold_o,
  output logic         idle_o,
  output logic [159:0] digest_o,
  output logic         digest_valid_o,
  input  logic         digest_ack_i
);

  localparam int R = RoundsPerCycle;
  localparam logic [6:0]   RStep = 7'(R);
  localparam logic [159:0] IV    = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 || R == 10 || R == 16 || R == 20))
  begin : g_bad_rounds_per_cycle
    $error("sha1_core: RoundsPerCycle must be one of 1,2,4,5,8,10,16,20");
  end

  typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_e;

  state_e      state_q;
  logic [6:0]  t_q;
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic [31:0] w_q [16];
  logic [159:0] h_q;
  logic        hold_q, idle_q, valid_q;

  logic [31:0] a_d, b_d, c_d, d_d, e_d;
  logic [31:0] w_d [16];
  logic        last_d;

  function automatic logic [31:0] f_fn(input logic [6:0] t, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_fn(input logic [6:0] t);
    if (t < 7'd20)      return 32'h5a827999;
    else if (t < 7'd40) return 32'h6ed9eba1;
    else if (t < 7'd60) return 32'h8f1bbcdc;
    else                return 32'hca62c1d6;
  endfunction

  // ext[i] holds W[t+i]; the message schedule recurrence is valid for every
  // extension index, so the window needs no special case for t < 16.
  always_comb begin : round_logic
    logic [31:0] ext [16+R];
    logic [31:0] a, b, c, d, e, tmp, wx;
    logic [6:0]  idx;
    tmp = '0;
    wx  = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int i = 16; i < 16 + R; i++) begin
      wx     = ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16];
      ext[i] = {wx[30:0], wx[31]};
    end
    a = a_q;
    b = b_q;
    c = c_q;
    d = d_q;
    e = e_q;
    for (int j = 0; j < R; j++) begin
      idx = t_q + 7'(j);
      tmp = {a[26:0], a[31:27]} + f_fn(idx, b, c, d) + e + k_fn(idx) + ext[j];
      e   = d;
      d   = c;
      c   = {b[1:0], b[31:2]};
      b   = a;
      a   = tmp;
    end
    a_d = a;
    b_d = b;
    c_d = c;
    d_d = d;
    e_d = e;
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
    last_d = (t_q + RStep == 7'd80);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      h_q     <= IV;
      hold_q  <= 1'b0;
      idle_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (reset_hash_i) begin
      h_q     <= IV;
      valid_q <= 1'b0;
      if (state_q == IDLE && enable_hash_i) begin
        for (int i = 0; i < 16; i++) w_q[i] <= block_i[511-32*i -: 32];
        {a_q, b_q, c_q, d_q, e_q} <= IV;
        t_q     <= '0;
        state_q <= ROUNDS;
        hold_q  <= 1'b1;
        idle_q  <= 1'b0;
      end else begin
        state_q <= IDLE;
        hold_q  <= 1'b0;
        idle_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_hash_i) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_i[511-32*i -: 32];
            {a_q, b_q, c_q, d_q, e_q} <= h_q;
            t_q     <= '0;
            state_q <= ROUNDS;
            hold_q  <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        ROUNDS: begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          d_q <= d_d;
          e_q <= e_d;
          for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
          t_q <= t_q + RStep;
          if (last_d) begin
            h_q <= {h_q[159:128] + a_d, h_q[127:96] + b_d, h_q[95:64] + c_d,
                    h_q[63:32] + d_d, h_q[31:0] + e_d};
            valid_q <= 1'b1;
            state_q <= DONE;
            hold_q  <= 1'b0;
          end
        end
        DONE: begin
          if (digest_ack_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign hold_o         = hold_q;
  assign idle_o         = idle_q;
  assign digest_o       = h_q;
  assign digest_valid_o = valid_q;

endmodule
